// File: rtl/sdram_lfsr_tester_if.sv
`default_nettype none
// ============================================================================
// Interface : sdram_lfsr_tester_if
// Purpose   : Burst write/read handshake between the LFSR tester and an SDRAM
//             burst controller.
// Revision  : 1.0
// ============================================================================
interface sdram_lfsr_tester_if #(
    parameter int ADDR_WIDTH     = 21,
    parameter int MEM_DATA_WIDTH = 32,
    parameter int BURST_WIDTH    = 10
);
    logic                      o_wr_burst_req;
    logic [BURST_WIDTH-1:0]    o_wr_burst_len;
    logic [ADDR_WIDTH-1:0]     o_wr_burst_addr;
    logic                      i_wr_burst_data_req;
    logic [MEM_DATA_WIDTH-1:0] o_wr_burst_data;
    logic                      i_wr_burst_finish;

    logic                      o_rd_burst_req;
    logic [BURST_WIDTH-1:0]    o_rd_burst_len;
    logic [ADDR_WIDTH-1:0]     o_rd_burst_addr;
    logic                      i_rd_burst_data_valid;
    logic [MEM_DATA_WIDTH-1:0] i_rd_burst_data;
    logic                      i_rd_burst_finish;

    modport master (
        output o_wr_burst_req, o_wr_burst_len, o_wr_burst_addr, o_wr_burst_data,
        input  i_wr_burst_data_req, i_wr_burst_finish,
        output o_rd_burst_req, o_rd_burst_len, o_rd_burst_addr,
        input  i_rd_burst_data_valid, i_rd_burst_data, i_rd_burst_finish
    );

    modport slave (
        input  o_wr_burst_req, o_wr_burst_len, o_wr_burst_addr, o_wr_burst_data,
        output i_wr_burst_data_req, i_wr_burst_finish,
        input  o_rd_burst_req, o_rd_burst_len, o_rd_burst_addr,
        output i_rd_burst_data_valid, i_rd_burst_data, i_rd_burst_finish
    );
endinterface
`default_nettype wire

// File: rtl/sdram_lfsr_tester.sv
`default_nettype none
// ============================================================================
// Module   : sdram_lfsr_tester
// Purpose  : Walks the whole SDRAM in bursts, writing an address-seeded LFSR
//            pattern and reading it back; sticky error flag and pass counter.
//            Optional watchdog enabled by defining SDRAM_TESTER_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module sdram_lfsr_tester #(
    parameter int          ADDR_WIDTH     = 21,
    parameter int          MEM_DATA_WIDTH = 32,
    parameter int          BURST_WIDTH    = 10,
    parameter int          BURST_LEN      = 128,
    parameter logic [31:0] LFSR_SEED      = 32'hACE1_1234
) (
    input  wire logic              i_sys_clk,
    input  wire logic              i_rst_n,
    sdram_lfsr_tester_if.master    bus,
    output logic                   o_wr_error,
    output logic [ADDR_WIDTH-1:0]  o_err_addr,
    output logic [15:0]            o_pass_cnt
);

    // Galois right-shift toggle mask for x^32 + x^22 + x^2 + x + 1
    localparam logic [31:0]            c_LFSR_POLY  = 32'h8020_0003;
    localparam logic [ADDR_WIDTH-1:0]  c_ADDR_STEP  = ADDR_WIDTH'(BURST_LEN);
    localparam logic [BURST_WIDTH-1:0] c_BURST_LEN  = BURST_WIDTH'(BURST_LEN);
    localparam logic [BURST_WIDTH:0]   c_CNT_TARGET = (BURST_WIDTH+1)'(BURST_LEN);
    localparam int                     c_REPS       = (MEM_DATA_WIDTH + 31) / 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WR   = 2'd1,
        S_RD   = 2'd2,
        S_NEXT = 2'd3
    } state_t;

    function automatic logic [31:0] f_lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? c_LFSR_POLY : 32'h0);
    endfunction

    // Narrow buses keep the LSBs, wide buses see the LFSR value repeated
    function automatic logic [MEM_DATA_WIDTH-1:0] f_expand(input logic [31:0] s);
        return MEM_DATA_WIDTH'({c_REPS{s}});
    endfunction

    state_t                    r_state;
    state_t                    w_state_nxt;
    logic [ADDR_WIDTH-1:0]     r_addr;
    logic [ADDR_WIDTH-1:0]     w_addr_nxt;
    logic [31:0]               r_wr_lfsr;
    logic [31:0]               r_rd_lfsr;
    logic [MEM_DATA_WIDTH-1:0] r_wr_data;
    logic [BURST_WIDTH:0]      r_rd_cnt;
    logic [BURST_WIDTH:0]      w_cnt_final;
    logic                      r_err;
    logic [ADDR_WIDTH-1:0]     r_err_addr;
    logic [15:0]               r_pass_cnt;
    logic                      w_in_burst;
    logic                      w_finish;
    logic                      w_timeout;
    logic                      w_mismatch;
    logic                      w_cnt_bad;
    logic                      w_err_evt;

    assign w_in_burst  = (r_state == S_WR) || (r_state == S_RD);
    assign w_finish    = ((r_state == S_WR) && bus.i_wr_burst_finish) ||
                         ((r_state == S_RD) && bus.i_rd_burst_finish);
    assign w_addr_nxt  = (r_state == S_NEXT) ? (r_addr + c_ADDR_STEP) : r_addr;
    assign w_cnt_final = r_rd_cnt + {{BURST_WIDTH{1'b0}}, bus.i_rd_burst_data_valid};

    assign w_mismatch = (r_state == S_RD) && bus.i_rd_burst_data_valid &&
                        (bus.i_rd_burst_data != f_expand(r_rd_lfsr));
    assign w_cnt_bad  = (r_state == S_RD) && bus.i_rd_burst_finish &&
                        (w_cnt_final != c_CNT_TARGET);
    assign w_err_evt  = w_mismatch || w_cnt_bad || w_timeout;

`ifdef SDRAM_TESTER_TIMEOUT_EN
    logic [15:0] r_wdog;

    assign w_timeout = w_in_burst && !w_finish && (r_wdog == 16'hFFFF);

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wdog <= 16'h0;
        end else if (w_in_burst && !w_finish && !w_timeout) begin
            r_wdog <= r_wdog + 16'h1;
        end else begin
            r_wdog <= 16'h0;
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            S_IDLE: w_state_nxt = S_WR;
            S_WR: begin
                if (bus.i_wr_burst_finish) begin
                    w_state_nxt = S_RD;
                end else if (w_timeout) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_RD: begin
                if (bus.i_rd_burst_finish || w_timeout) begin
                    w_state_nxt = S_NEXT;
                end
            end
            S_NEXT:  w_state_nxt = S_WR;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_sys_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_addr     <= '0;
            r_wr_lfsr  <= 32'h0;
            r_rd_lfsr  <= 32'h0;
            r_wr_data  <= '0;
            r_rd_cnt   <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_pass_cnt <= 16'h0;
        end else begin
            r_addr <= w_addr_nxt;

            if ((r_state != S_WR) && (w_state_nxt == S_WR)) begin
                r_wr_lfsr <= LFSR_SEED ^ 32'(w_addr_nxt);
            end else if ((r_state == S_WR) && bus.i_wr_burst_data_req) begin
                r_wr_data <= f_expand(r_wr_lfsr);
                r_wr_lfsr <= f_lfsr_next(r_wr_lfsr);
            end

            if ((r_state == S_WR) && (w_state_nxt == S_RD)) begin
                r_rd_lfsr <= LFSR_SEED ^ 32'(r_addr);
                r_rd_cnt  <= '0;
            end else if ((r_state == S_RD) && bus.i_rd_burst_data_valid) begin
                r_rd_lfsr <= f_lfsr_next(r_rd_lfsr);
                if (r_rd_cnt != '1) begin
                    r_rd_cnt <= r_rd_cnt + 1'b1;
                end
            end

            if (w_err_evt) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= r_addr;
                end
            end

            if ((r_state == S_NEXT) && (w_addr_nxt == '0) && (r_pass_cnt != 16'hFFFF)) begin
                r_pass_cnt <= r_pass_cnt + 16'h1;
            end
        end
    end

    assign bus.o_wr_burst_req  = (r_state == S_WR);
    assign bus.o_wr_burst_len  = c_BURST_LEN;
    assign bus.o_wr_burst_addr = r_addr;
    assign bus.o_wr_burst_data = r_wr_data;
    assign bus.o_rd_burst_req  = (r_state == S_RD);
    assign bus.o_rd_burst_len  = c_BURST_LEN;
    assign bus.o_rd_burst_addr = r_addr;

    assign o_wr_error = r_err;
    assign o_err_addr = r_err_addr;
    assign o_pass_cnt = r_pass_cnt;

endmodule
`default_nettype wire

// File: tb/tb_sdram_lfsr_tester.sv
`default_nettype none
// ============================================================================
// Module   : tb_sdram_lfsr_tester
// Purpose  : Ideal burst-controller model with write-data scoreboard for
//            sdram_lfsr_tester (ADDR_WIDTH=10 so a full pass is 8 bursts).
// Revision : 1.0
// ============================================================================
module tb_sdram_lfsr_tester;

    localparam int          AW   = 10;
    localparam int          DW   = 32;
    localparam int          BW   = 10;
    localparam int          BL   = 128;
    localparam logic [31:0] SEED = 32'hACE1_1234;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sdram_lfsr_tester_if #(.ADDR_WIDTH(AW), .MEM_DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus ();

    logic          err;
    logic [AW-1:0] err_addr;
    logic [15:0]   pass_cnt;

    sdram_lfsr_tester #(
        .ADDR_WIDTH     (AW),
        .MEM_DATA_WIDTH (DW),
        .BURST_WIDTH    (BW),
        .BURST_LEN      (BL),
        .LFSR_SEED      (SEED)
    ) dut (
        .i_sys_clk  (clk),
        .i_rst_n    (rst_n),
        .bus        (bus),
        .o_wr_error (err),
        .o_err_addr (err_addr),
        .o_pass_cnt (pass_cnt)
    );

    int            n_vec = 0;
    int            n_fail = 0;
    logic [31:0]   mem [0:1023];
    logic [31:0]   exp_q [$];
    logic          exp_err;
    logic [AW-1:0] exp_err_addr;
    logic [15:0]   exp_pass;

    function automatic logic [31:0] lfsr_next(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? 32'h8020_0003 : 32'h0);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wr_req"},   32'(bus.o_wr_burst_req),  32'h0);
        check({tag, "_rd_req"},   32'(bus.o_rd_burst_req),  32'h0);
        check({tag, "_wr_data"},  bus.o_wr_burst_data,      32'h0);
        check({tag, "_wr_addr"},  32'(bus.o_wr_burst_addr), 32'h0);
        check({tag, "_err"},      32'(err),                 32'h0);
        check({tag, "_err_addr"}, 32'(err_addr),            32'h0);
        check({tag, "_pass_cnt"}, 32'(pass_cnt),            32'h0);
    endtask

    task automatic wait_req(input bit rd, input logic [AW-1:0] a);
        for (int n = 0; n < 64 && ((rd ? bus.o_rd_burst_req : bus.o_wr_burst_req) !== 1'b1); n++)
            @(negedge clk);
        if (rd) begin
            check("rd_req",  32'(bus.o_rd_burst_req),  32'h1);
            check("rd_addr", 32'(bus.o_rd_burst_addr), 32'(a));
            check("rd_len",  32'(bus.o_rd_burst_len),  BL);
            check("wr_req_excl", 32'(bus.o_wr_burst_req), 32'h0);
        end else begin
            check("wr_req",  32'(bus.o_wr_burst_req),  32'h1);
            check("wr_addr", 32'(bus.o_wr_burst_addr), 32'(a));
            check("wr_len",  32'(bus.o_wr_burst_len),  BL);
            check("rd_req_excl", 32'(bus.o_rd_burst_req), 32'h0);
        end
    endtask

    // abort_at >= 0 pulls reset low while that word is being requested
    task automatic write_burst(input logic [AW-1:0] a, input int abort_at, input bit noise);
        logic [31:0] l;
        logic [31:0] e;
        wait_req(1'b0, a);
        l = SEED ^ 32'(a);
        for (int i = 0; i <= BL; i++) begin
            if (i > 0) begin
                e = exp_q.pop_front();
                check("wr_data", bus.o_wr_burst_data, e);
                mem[int'(a) + i - 1] = bus.o_wr_burst_data;
            end
            if (i == abort_at) begin
                rst_n = 1'b0;
                bus.i_wr_burst_data_req = 1'b0;
                exp_q.delete();
                #1;
                check_all_zero("async_rst");
                return;
            end
            if (i < BL) begin
                bus.i_wr_burst_data_req = 1'b1;
                exp_q.push_back(l);
                l = lfsr_next(l);
            end else begin
                bus.i_wr_burst_data_req = 1'b0;
            end
            bus.i_rd_burst_data_valid = noise && (i == 10);
            bus.i_rd_burst_finish     = noise && (i == 10);
            bus.i_rd_burst_data       = 32'hDEAD_BEEF;
            @(negedge clk);
        end
        bus.i_wr_burst_finish = 1'b1;
        @(negedge clk);
        bus.i_wr_burst_finish = 1'b0;
        check("wr_req_drop", 32'(bus.o_wr_burst_req), 32'h0);
    endtask

    task automatic read_burst(input logic [AW-1:0] a, input int corrupt, input int n_valid);
        wait_req(1'b1, a);
        for (int i = 0; i <= n_valid; i++) begin
            if (i > 0 && i - 1 == corrupt)
                check("err_next_cycle", 32'(err), 32'h1);
            if (i < n_valid) begin
                bus.i_rd_burst_data_valid = 1'b1;
                bus.i_rd_burst_data = mem[int'(a) + i] ^ ((i == corrupt) ? 32'h1 : 32'h0);
            end else begin
                bus.i_rd_burst_data_valid = 1'b0;
                bus.i_rd_burst_data = 32'h0;
            end
            @(negedge clk);
        end
        bus.i_rd_burst_finish = 1'b1;
        @(negedge clk);
        bus.i_rd_burst_finish = 1'b0;
        check("rd_req_drop", 32'(bus.o_rd_burst_req), 32'h0);
    endtask

    task automatic pair(input logic [AW-1:0] a, input int corrupt, input int n_valid, input bit noise);
        write_burst(a, -1, noise);
        read_burst(a, corrupt, n_valid);
        if (corrupt >= 0 || n_valid != BL) begin
            if (!exp_err) exp_err_addr = a;
            exp_err = 1'b1;
        end
        check("err",      32'(err),      32'(exp_err));
        check("err_addr", 32'(err_addr), 32'(exp_err_addr));
        @(negedge clk);
        if (int'(a) + BL == (1 << AW)) exp_pass++;
        check("pass_cnt", 32'(pass_cnt), 32'(exp_pass));
    endtask

    initial begin
        bus.i_wr_burst_data_req   = 1'b0;
        bus.i_wr_burst_finish     = 1'b0;
        bus.i_rd_burst_data_valid = 1'b0;
        bus.i_rd_burst_data       = 32'h0;
        bus.i_rd_burst_finish     = 1'b0;
        exp_err      = 1'b0;
        exp_err_addr = '0;
        exp_pass     = 16'h0;

        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n = 1'b1;

        // One full clean pass; stray read strobes injected during the A=128 write
        for (int k = 0; k < 8; k++)
            pair(AW'(k * BL), -1, BL, k == 1);
        check("addr_wrap", 32'(bus.o_wr_burst_addr), 32'h0);

        // Second pass: first error at 256, later error at 512 must not move err_addr
        pair(AW'(0),   -1, BL, 1'b0);
        pair(AW'(128), -1, BL, 1'b0);
        pair(AW'(256),  5, BL, 1'b0);
        pair(AW'(384), -1, BL, 1'b0);
        pair(AW'(512), 20, BL, 1'b0);

        // Reset while word 40 of the A=640 write is in flight
        write_burst(AW'(640), 40, 1'b0);
        repeat (2) @(negedge clk);
        check_all_zero("in_reset");
        rst_n        = 1'b1;
        exp_err      = 1'b0;
        exp_err_addr = '0;
        exp_pass     = 16'h0;

        pair(AW'(0),   -1, BL,     1'b1);
        pair(AW'(128), -1, BL - 1, 1'b0);

`ifdef SDRAM_TESTER_TIMEOUT_EN
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        wait_req(1'b0, AW'(0));
        for (int n = 0; n < 70000 && bus.o_wr_burst_req === 1'b1; n++)
            @(negedge clk);
        check("wdog_err",    32'(err),                32'h1);
        check("wdog_wr_req", 32'(bus.o_wr_burst_req), 32'h0);
        check("wdog_addr",   32'(err_addr),           32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/sdram_lfsr_tester.md
SDRAM_LFSR_TESTER -- requirements
Module: sdram_lfsr_tester

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 21, word address width (bank+row+col).
REQ-002 SHALL have parameter MEM_DATA_WIDTH, default 32, data word width.
REQ-003 SHALL have parameter BURST_WIDTH, default 10, width of burst length fields.
REQ-004 SHALL have parameter BURST_LEN, default 128, words per burst, range 1..2^BURST_WIDTH-1, power of two.
REQ-005 SHALL have parameter LFSR_SEED, default 32'hACE1_1234, pattern seed, nonzero.
REQ-006 i_sys_clk  in  1  single clock, all logic rising-edge.
REQ-007 i_rst_n  in  1  reset, asynchronous, active-low.
REQ-008 o_wr_burst_req / o_wr_burst_len / o_wr_burst_addr  out  1 / BURST_WIDTH / ADDR_WIDTH  write burst request, length, base address.
REQ-009 i_wr_burst_data_req  in  1  controller requests the next write word; the word is sampled one cycle later.
REQ-010 o_wr_burst_data  out  MEM_DATA_WIDTH  write data.
REQ-011 i_wr_burst_finish  in  1  single-cycle pulse, write burst done.
REQ-012 o_rd_burst_req / o_rd_burst_len / o_rd_burst_addr  out  1 / BURST_WIDTH / ADDR_WIDTH  read burst request, length, base address.
REQ-013 i_rd_burst_data_valid / i_rd_burst_data  in  1 / MEM_DATA_WIDTH  read word strobe and data.
REQ-014 i_rd_burst_finish  in  1  single-cycle pulse, read burst done.
REQ-015 o_wr_error  out  1  sticky error flag (drives LED; 0 = pass).
REQ-016 o_err_addr  out  ADDR_WIDTH  base address of the first failing burst.
REQ-017 o_pass_cnt  out  16  completed full-memory passes, saturating at 16'hFFFF.

Function
REQ-018 FSM states: IDLE, WR, RD, NEXT; IDLE->WR one cycle after reset release.
REQ-019 WR: assert o_wr_burst_req at base address A, length BURST_LEN; hold until i_wr_burst_finish, deassert in the following cycle, go to RD.
REQ-020 RD: assert o_rd_burst_req at the same A, length BURST_LEN; hold until i_rd_burst_finish, deassert in the following cycle, go to NEXT.
REQ-021 NEXT (one cycle): A <= A + BURST_LEN modulo 2^ADDR_WIDTH; on wrap to 0, increment o_pass_cnt (saturating); then go to WR.
REQ-022 Write pattern: a 32-bit Galois LFSR (poly x^32+x^22+x^2+x+1), loaded at WR entry with LFSR_SEED XOR zero-extended A, advanced once per i_wr_burst_data_req; o_wr_burst_data is registered and valid the cycle after each data_req.
REQ-023 Read checker: an identical LFSR, loaded at RD entry with the same value, advanced once per i_rd_burst_data_valid; a mismatch sets o_wr_error.
REQ-024 MEM_DATA_WIDTH < 32 uses the LFSR LSBs; MEM_DATA_WIDTH > 32 replicates the LFSR value.
REQ-025 Read word count: if the count of valid strobes at i_rd_burst_finish is not equal to BURST_LEN, set o_wr_error.
REQ-026 o_err_addr latches A only on the first error; o_wr_error stays set until reset; testing continues after an error.
REQ-027 Finish pulses and data strobes received in a state that does not expect them are ignored.
REQ-028 The FSM never asserts o_wr_burst_req and o_rd_burst_req in the same cycle.

Reset
REQ-029 Asynchronous assert on i_rst_n low. All outputs reset to 0: requests, data, error, o_err_addr, o_pass_cnt. A resets to 0; FSM resets to IDLE.
REQ-030 Reset mid-burst drops the request immediately; after release, testing restarts at A=0 with fresh LFSR loads.
REQ-031 Length outputs are constant BURST_LEN and are exempt from REQ-029.

Configuration
REQ-032 Macro SDRAM_TESTER_TIMEOUT_EN defined: a 16-bit watchdog counts cycles in WR/RD, clears on each finish pulse; on reaching 16'hFFFF it sets o_wr_error, latches o_err_addr (if first error), drops the request and goes to NEXT.
REQ-033 Macro undefined: no watchdog logic; WR/RD wait indefinitely.

Verification
REQ-034 Ideal controller model, BURST_LEN=128 -> 128 words written and read back at A=0 and A=128, then o_wr_error=0.
REQ-035 Model corrupts bit0 of read word 5 at A=256 -> o_wr_error=1 on the following cycle, o_err_addr=256; a later error at A=512 leaves o_err_addr=256.
REQ-036 Model asserts only 127 valid strobes before rd_finish -> o_wr_error=1.
REQ-037 ADDR_WIDTH=10, BURST_LEN=128 -> o_pass_cnt=1 after 8 write/read pairs; A returns to 0.
REQ-038 i_rst_n low during WR word 40 -> all outputs are 0 asynchronously; after release, first o_wr_burst_addr=0 and the first data word equals the LFSR output seeded with LFSR_SEED.
REQ-039 With SDRAM_TESTER_TIMEOUT_EN defined, the model never pulses wr_finish -> after 65535 cycles o_wr_error=1 and o_wr_burst_req=0.
